// File: rtl/cls_16bit.sv
// Registered 16-bit carry-select adder built from 16/BLOCK_W blocks.
// Optional signed-overflow output enabled by CLS_16BIT_OVERFLOW_EN.
module cls_16bit #(
    parameter int BLOCK_W = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        carry_start,
    output logic [15:0] sum,
    output logic        carry_out
`ifdef CLS_16BIT_OVERFLOW_EN
    ,
    output logic        overflow
`endif
);

    localparam int NB = 16 / BLOCK_W;

    logic [NB:0]  carry;
    logic [15:0]  sum_next;

    assign carry[0] = carry_start;

    genvar i;
    generate
        for (i = 0; i < NB; i++) begin : g_blk
            logic [BLOCK_W-1:0] a_blk;
            logic [BLOCK_W-1:0] b_blk;

            assign a_blk = a[i*BLOCK_W +: BLOCK_W];
            assign b_blk = b[i*BLOCK_W +: BLOCK_W];

            if (i == 0) begin : g_ripple
                logic [BLOCK_W:0] rc;
                logic [BLOCK_W-1:0] rs;

                always_comb begin
                    rc    = '0;
                    rs    = '0;
                    rc[0] = carry[0];
                    for (int k = 0; k < BLOCK_W; k++) begin
                        rs[k]   = a_blk[k] ^ b_blk[k] ^ rc[k];
                        rc[k+1] = (a_blk[k] & b_blk[k])
                                | (rc[k] & (a_blk[k] ^ b_blk[k]));
                    end
                end

                assign sum_next[BLOCK_W-1:0] = rs;
                assign carry[1]              = rc[BLOCK_W];
            end else begin : g_select
                // Both carry-in cases are ready before the lower carry lands.
                logic [BLOCK_W:0] r0;
                logic [BLOCK_W:0] r1;

                assign r0 = {1'b0, a_blk} + {1'b0, b_blk};
                assign r1 = {1'b0, a_blk} + {1'b0, b_blk}
                          + {{BLOCK_W{1'b0}}, 1'b1};

                assign sum_next[i*BLOCK_W +: BLOCK_W] =
                    carry[i] ? r1[BLOCK_W-1:0] : r0[BLOCK_W-1:0];
                assign carry[i+1] =
                    carry[i] ? r1[BLOCK_W] : r0[BLOCK_W];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            sum       <= 16'h0000;
            carry_out <= 1'b0;
        end else begin
            sum       <= sum_next;
            carry_out <= carry[NB];
        end
    end

`ifdef CLS_16BIT_OVERFLOW_EN
    logic overflow_next;

    assign overflow_next = (a[15] == b[15]) && (sum_next[15] != a[15]);

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else begin
            overflow <= overflow_next;
        end
    end
`endif

endmodule

// File: tb/tb_cls_16bit.sv
// Bench for cls_16bit: three block widths side by side against
// an integer-arithmetic model, directed corners then random traffic.
module tb_cls_16bit;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] a;
    logic [15:0] b;
    logic        carry_start;
    logic [15:0] sum_q [3];
    logic        co_q  [3];
`ifdef CLS_16BIT_OVERFLOW_EN
    logic        ov_q  [3];
`endif

    int checks = 0;
    int errors = 0;

    logic [16:0] exp_res;
    logic        exp_ov;

    always #5 clk = ~clk;

    cls_16bit #(.BLOCK_W(2)) dut2 (
        .clk(clk), .reset(reset), .a(a), .b(b),
        .carry_start(carry_start),
        .sum(sum_q[0]), .carry_out(co_q[0])
`ifdef CLS_16BIT_OVERFLOW_EN
        , .overflow(ov_q[0])
`endif
    );

    cls_16bit #(.BLOCK_W(4)) dut4 (
        .clk(clk), .reset(reset), .a(a), .b(b),
        .carry_start(carry_start),
        .sum(sum_q[1]), .carry_out(co_q[1])
`ifdef CLS_16BIT_OVERFLOW_EN
        , .overflow(ov_q[1])
`endif
    );

    cls_16bit #(.BLOCK_W(8)) dut8 (
        .clk(clk), .reset(reset), .a(a), .b(b),
        .carry_start(carry_start),
        .sum(sum_q[2]), .carry_out(co_q[2])
`ifdef CLS_16BIT_OVERFLOW_EN
        , .overflow(ov_q[2])
`endif
    );

    // Reference: plain integer add, overflow judged by signed range.
    task automatic model(input logic r, input logic [15:0] ai,
                         input logic [15:0] bi, input logic ci);
        int u;
        int s;
        if (r) begin
            exp_res = '0;
            exp_ov  = 1'b0;
        end else begin
            u       = int'(ai) + int'(bi) + int'(ci);
            exp_res = u[16:0];
            s       = int'($signed(ai)) + int'($signed(bi)) + int'(ci);
            exp_ov  = (s > 32767) || (s < -32768);
        end
    endtask

    task automatic compare(input string tag);
        for (int k = 0; k < 3; k++) begin
            checks++;
            assert ({co_q[k], sum_q[k]} === exp_res) else begin
                errors++;
                $error("FAIL %s w%0d got co=%b sum=%h exp co=%b sum=%h",
                       tag, k, co_q[k], sum_q[k], exp_res[16], exp_res[15:0]);
            end
`ifdef CLS_16BIT_OVERFLOW_EN
            checks++;
            assert (ov_q[k] === exp_ov) else begin
                errors++;
                $error("FAIL %s_ov w%0d got %b exp %b",
                       tag, k, ov_q[k], exp_ov);
            end
`endif
        end
    endtask

    // One edge per call, so consecutive calls are back-to-back.
    task automatic apply(input logic r, input logic [15:0] ai,
                         input logic [15:0] bi, input logic ci,
                         input string tag);
        @(negedge clk);
        reset       = r;
        a           = ai;
        b           = bi;
        carry_start = ci;
        model(r, ai, bi, ci);
        @(posedge clk);
        #1;
        compare(tag);
        #1;
        a           = 16'($urandom);
        b           = 16'($urandom);
        carry_start = 1'($urandom);
        #1;
        compare({tag, "_hold"});
    endtask

    initial begin
        reset       = 1'b1;
        a           = 16'h0;
        b           = 16'h0;
        carry_start = 1'b0;

        apply(1'b1, 16'hFFFF, 16'hFFFF, 1'b1, "reset_state");
        apply(1'b0, 16'h0000, 16'h0000, 1'b1, "first_after_rst");
        apply(1'b0, 16'hFFFF, 16'h0000, 1'b1, "wrap");
        apply(1'b0, 16'hFFFF, 16'hFFFF, 1'b1, "max");
        apply(1'b0, 16'h1234, 16'h4321, 1'b0, "mid_c0");
        apply(1'b0, 16'h1234, 16'h4321, 1'b1, "mid_c1");
        apply(1'b0, 16'h00FF, 16'h0001, 1'b0, "blk_carry");
        apply(1'b0, 16'h0FFF, 16'h0000, 1'b1, "chain");
        apply(1'b1, 16'hFFFF, 16'hFFFF, 1'b0, "rst_midstream");
        apply(1'b0, 16'hABCD, 16'h1111, 1'b0, "after_rst");
        apply(1'b0, 16'h7FFF, 16'h0001, 1'b0, "ov_pos");
        apply(1'b0, 16'hFFFF, 16'h0001, 1'b0, "no_ov_neg");
        apply(1'b0, 16'h8000, 16'h8000, 1'b0, "ov_neg");
        apply(1'b0, 16'h7FFF, 16'h0000, 1'b1, "ov_cin");

        for (int n = 0; n < 300; n++) begin
            apply(($urandom_range(0, 15) == 0),
                  16'($urandom), 16'($urandom),
                  1'($urandom), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cls_16bit.md
CLS_16BIT -- requirements
Module: cls_16bit

Interface
REQ-001 SHALL have parameter BLOCK_W, default 4, giving the carry-select block width in bits; legal values are 2, 4 and 8 (divisors of 16).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port a, input, 16 bits: addend A, unsigned (two's complement when overflow is enabled).
REQ-005 SHALL have port b, input, 16 bits: addend B.
REQ-006 SHALL have port carry_start, input, 1 bit: carry-in to bit 0.
REQ-007 SHALL have port sum, output, 16 bits: registered result bits [15:0].
REQ-008 SHALL have port carry_out, output, 1 bit: registered carry out of bit 15.
REQ-009 SHALL have port overflow, output, 1 bit: registered signed-overflow flag, present only under CLS_16BIT_OVERFLOW_EN.

Function
REQ-010 SHALL compute the 17-bit value {carry_out, sum} = a + b + carry_start, modulo 2^17; no saturation.
REQ-011 SHALL build the adder as a carry-select structure of 16/BLOCK_W blocks:
- block 0 ripples from carry_start;
- each higher block precomputes the sum and carry for carry-in 0 and for carry-in 1;
- the previous block's selected carry muxes between the two.
REQ-012 SHALL register sum and carry_out on every rising clk edge while reset is low: latency is exactly 1 cycle from input sampling, with one new result per cycle and no handshake.
REQ-013 SHALL treat a, b and carry_start as sampled only at the clock edge; input changes between edges SHALL have no effect on the outputs.
REQ-014 SHALL wrap at the boundary: a = FFFF, b = 0000, carry_start = 1 gives sum 0000 and carry_out 1.
REQ-015 SHALL give the maximum case a = FFFF, b = FFFF, carry_start = 1 as sum FFFF and carry_out 1.
REQ-016 SHALL produce a result for any BLOCK_W that is bit-identical to the behavioural a + b + carry_start.

Reset
REQ-017 SHALL, when reset is high at a rising clk edge, load sum = 0000, carry_out = 0 and overflow = 0.
REQ-018 SHALL give reset priority over a simultaneous input update; reset asserted mid-stream discards the pending result.
REQ-019 SHALL present the result of inputs sampled at the first edge with reset low at the following edge (first valid output one cycle after reset release).

Configuration
REQ-020 SHALL, with macro CLS_16BIT_OVERFLOW_EN defined, add output overflow, registered with the same latency as sum, equal to (a[15] == b[15]) && (sum_next[15] != a[15]).
REQ-021 SHALL, without CLS_16BIT_OVERFLOW_EN, omit the overflow port and its logic entirely; all other behaviour is unchanged.

Verification
REQ-022 SHALL verify a = 0000, b = 0000, carry_start = 1 -> after 1 edge, sum = 0001 and carry_out = 0.
REQ-023 SHALL verify a = FFFF, b = 0000, carry_start = 1 -> sum = 0000 and carry_out = 1; and a = FFFF, b = FFFF, carry_start = 1 -> sum = FFFF and carry_out = 1.
REQ-024 SHALL verify a = 1234, b = 4321, carry_start = 0 -> sum = 5555 and carry_out = 0; with carry_start = 1 -> sum = 5556.
REQ-025 SHALL verify back-to-back inputs on consecutive edges -> each result appears exactly one edge later, with no bubbles.
REQ-026 SHALL verify reset high with a = FFFF, b = FFFF -> sum = 0000 and carry_out = 0 at that edge; after reset is released, the correct result follows one edge later.
REQ-027 SHALL, with CLS_16BIT_OVERFLOW_EN, verify a = 7FFF, b = 0001, carry_start = 0 -> sum = 8000 and overflow = 1; and a = FFFF, b = 0001 -> overflow = 0 and carry_out = 1.
